seq_divider: RTL

//  Parametrised multi-cycle integer divider for the CPU execute stage (DIV/DIVU).

---
 rtl/seq_divider.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Radix-2 restoring integer divider, one quotient bit per clock, signed or unsigned per operation.
// Optional SEQ_DIVIDER_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dbz_pend_q, dbz_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   q_res_q, q_res_d;
  logic [WIDTH-1:0]   r_res_q, r_res_d;

  logic [WIDTH-1:0]   dd_mag;
  logic [WIDTH-1:0]   dv_mag;
  logic [WIDTH:0]     trial;

  assign dd_mag = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign dv_mag = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

  // One extra bit: the shifted remainder can exceed WIDTH bits before subtraction.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dbz_pend_d = dbz_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    q_res_d    = q_res_q;
    r_res_d    = r_res_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d     = 1'b1;
          cnt_d      = '0;
          dvs_d      = dv_mag;
          q_neg_d    = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d    = is_signed & dividend[WIDTH-1];
          rem_d      = '0;
          quo_d      = dd_mag;
          dbz_pend_d = (divisor == '0);
          // Zero divisor: remainder path re-applies the dividend sign, reproducing the raw dividend.
          if (divisor == '0) begin
            rem_d   = dd_mag;
            state_d = S_FIX;
          end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          else if (dd_mag < dv_mag) begin
            rem_d   = dd_mag;
            quo_d   = '0;
            state_d = S_FIX;
          end
`endif
          else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        q_res_d = dbz_pend_q ? '1 : (q_neg_q ? (~quo_q + 1'b1) : quo_q);
        r_res_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        dbz_d   = dbz_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      q_res_q    <= '0;
      r_res_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      q_res_q    <= q_res_d;
      r_res_q    <= r_res_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign q    = q_res_q;
  assign r    = r_res_q;

endmodule
